// File: rtl/v_priority_pkg.sv
// rtl/v_priority_pkg.sv - shared types and helpers for the priority scanner
// Purpose: FSM state encoding and the clog2 helper used to size index ports.
// Ports: none (package).
package v_priority_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Smallest r with 2**r >= value; elaboration-time only.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/v_pe_find_first.sv
// rtl/v_pe_find_first.sv - combinational find-first-set with one-hot result
// Purpose: locate the highest-priority set bit of vec.
// Ports:
//   vec     in   WIDTH  vector to search
//   idx     out  IDX_W  index of the priority bit (0 when vec is zero)
//   found   out  1      vec has at least one bit set
//   onehot  out  WIDTH  one-hot mask of the priority bit (0 when vec is zero)
// MSB_FIRST=1 gives bit WIDTH-1 top priority, otherwise bit 0.
module v_pe_find_first
  import v_priority_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int IDX_W    = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found,
  output logic [WIDTH-1:0] onehot
);

  // The loop walks toward the top-priority end so the last hit wins.
  always_comb begin
    idx    = '0;
    onehot = '0;
    found  = |vec;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) begin
          idx       = IDX_W'(i);
          onehot    = '0;
          onehot[i] = 1'b1;
        end
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) begin
          idx       = IDX_W'(i);
          onehot    = '0;
          onehot[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/v_priority_scanner.sv
// rtl/v_priority_scanner.sv - registered scanner emitting each set-bit index per beat
// Purpose: latch a select vector and stream the index of every set bit,
//   lowest index first, or highest first when V_PRIORITY_SCANNER_MSB_FIRST_EN
//   is defined. An all-zero vector yields a single out_none beat.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_sel sampled on transfer
//   in_sel    [WIDTH]     select vector
//   out_valid/out_ready   output handshake
//   out_code  [IDX_W]     index of the current set bit
//   out_last              final beat of this vector
//   out_none              latched vector was all-zero
module v_priority_scanner
  import v_priority_pkg::*;
#(
  parameter int WIDTH  = 8,
  localparam int IDX_W = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_code,
  output logic             out_last,
  output logic             out_none
);

`ifdef V_PRIORITY_SCANNER_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  state_t           state, state_nxt;
  // mask holds the bits still to be emitted after the beat currently on
  // the outputs, so the next beat is found with a single search.
  logic [WIDTH-1:0] mask, mask_nxt;
  logic [WIDTH-1:0] src, src_rest, src_onehot, rest_onehot;
  logic [IDX_W-1:0] src_idx, rest_idx;
  logic             src_found, rest_found;
  logic             accept, xfer, load;
  logic             out_valid_nxt, out_last_nxt, out_none_nxt;
  logic [IDX_W-1:0] out_code_nxt;
  logic             unused_rest;

  v_pe_find_first #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_find_cur (
    .vec    (src),
    .idx    (src_idx),
    .found  (src_found),
    .onehot (src_onehot)
  );

  // Searching what remains after the chosen bit tells us whether the
  // beat being loaded is the last one.
  v_pe_find_first #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_find_rest (
    .vec    (src_rest),
    .idx    (rest_idx),
    .found  (rest_found),
    .onehot (rest_onehot)
  );

  assign unused_rest = ^{rest_idx, rest_onehot};

  always_comb begin
    state_nxt     = state;
    mask_nxt      = mask;
    out_valid_nxt = out_valid;
    out_code_nxt  = out_code;
    out_last_nxt  = out_last;
    out_none_nxt  = out_none;

    xfer     = out_valid && out_ready;
    in_ready = (state == ST_IDLE) || (xfer && out_last);
    accept   = in_valid && in_ready;
    // A new beat is loaded either from a freshly accepted vector or from
    // the remaining mask after a non-final transfer.
    load     = accept || (xfer && !out_last);
    src      = accept ? in_sel : mask;
    src_rest = src & ~src_onehot;

    if (load) begin
      state_nxt     = ST_EMIT;
      mask_nxt      = src_rest;
      out_valid_nxt = 1'b1;
      out_code_nxt  = src_idx;
      out_last_nxt  = !rest_found;
      out_none_nxt  = !src_found;
    end else if (xfer) begin
      state_nxt     = ST_IDLE;
      mask_nxt      = '0;
      out_valid_nxt = 1'b0;
      out_code_nxt  = '0;
      out_last_nxt  = 1'b0;
      out_none_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mask      <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_last  <= 1'b0;
      out_none  <= 1'b0;
    end else begin
      state     <= state_nxt;
      mask      <= mask_nxt;
      out_valid <= out_valid_nxt;
      out_code  <= out_code_nxt;
      out_last  <= out_last_nxt;
      out_none  <= out_none_nxt;
    end
  end

endmodule
